// File: rtl/bus_master.sv
// bus_master: command-driven burst master for the 256x8 packed-field memory slave.
// Write bytes are buffered before the address phase, and read beats are forwarded
// to the client as they arrive. Every bus-wait state is guarded by a timeout.
module bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_id,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_err,
    output logic        rd_last,
    output logic        done,
    output logic        done_err,
    output logic        done_timeout,
    output logic [3:0]  done_id,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [15:0] AR_OUT,
    output logic        RREADY,
    input  logic        RVALID,
    input  logic        RLAST,
    input  logic [8:0]  R_IN,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [11:0] AW_OUT,
    output logic        WVALID,
    input  logic        WREADY,
    output logic        WLAST,
    output logic [7:0]  WDATA,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [4:0]  BRESP
);

    typedef enum logic [2:0] {S_IDLE, S_WFILL, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  len_q, len_d, id_q, id_d, cnt_q, cnt_d;
    logic        err_q, err_d, tmo_q, tmo_d, over_q, over_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [7:0]  wbuf [16];
    logic        buf_we, hs, bus_wait, tmo_hit;

    logic        wr_ready_d, rd_valid_d, rd_err_d, rd_last_d, done_d, done_err_d, done_timeout_d;
    logic [7:0]  rd_data_d, WDATA_d;
    logic [3:0]  done_id_d;
    logic        ARVALID_d, RREADY_d, AWVALID_d, WVALID_d, WLAST_d, BREADY_d;
    logic [15:0] AR_OUT_d;
    logic [11:0] AW_OUT_d;

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign tmo_hit   = (tcnt_q == 8'(TIMEOUT - 1));

    // Write buffer: no reset needed, contents are only read after being filled.
    always_ff @(posedge clk) begin
        if (buf_we) wbuf[cnt_q] <= wr_data;
    end

    // State, context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q <= '0; len_q <= '0; id_q <= '0; cnt_q <= '0;
            err_q <= 1'b0; tmo_q <= 1'b0; over_q <= 1'b0; tcnt_q <= '0;
            wr_ready <= 1'b0; rd_valid <= 1'b0; rd_data <= '0; rd_err <= 1'b0; rd_last <= 1'b0;
            done <= 1'b0; done_err <= 1'b0; done_timeout <= 1'b0; done_id <= '0;
            ARVALID <= 1'b0; AR_OUT <= '0; RREADY <= 1'b0;
            AWVALID <= 1'b0; AW_OUT <= '0; WVALID <= 1'b0; WLAST <= 1'b0; WDATA <= '0;
            BREADY <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d; len_q <= len_d; id_q <= id_d; cnt_q <= cnt_d;
            err_q <= err_d; tmo_q <= tmo_d; over_q <= over_d; tcnt_q <= tcnt_d;
            wr_ready <= wr_ready_d; rd_valid <= rd_valid_d; rd_data <= rd_data_d;
            rd_err <= rd_err_d; rd_last <= rd_last_d;
            done <= done_d; done_err <= done_err_d; done_timeout <= done_timeout_d; done_id <= done_id_d;
            ARVALID <= ARVALID_d; AR_OUT <= AR_OUT_d; RREADY <= RREADY_d;
            AWVALID <= AWVALID_d; AW_OUT <= AW_OUT_d; WVALID <= WVALID_d; WLAST <= WLAST_d;
            WDATA <= WDATA_d; BREADY <= BREADY_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one edge ahead so they leave registered.
    always_comb begin
        state_d = state_q;
        addr_d = addr_q; len_d = len_q; id_d = id_q; cnt_d = cnt_q;
        err_d = err_q; tmo_d = tmo_q; over_d = over_q; tcnt_d = tcnt_q;
        buf_we = 1'b0; hs = 1'b0; bus_wait = 1'b0;
        wr_ready_d = wr_ready; rd_valid_d = 1'b0; rd_data_d = rd_data;
        rd_err_d = 1'b0; rd_last_d = 1'b0;
        done_d = 1'b0; done_err_d = done_err; done_timeout_d = done_timeout; done_id_d = done_id;
        ARVALID_d = ARVALID; AR_OUT_d = AR_OUT; RREADY_d = RREADY;
        AWVALID_d = AWVALID; AW_OUT_d = AW_OUT; WVALID_d = WVALID; WLAST_d = WLAST;
        WDATA_d = WDATA; BREADY_d = BREADY;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr; len_d = cmd_len; id_d = cmd_id;
                    cnt_d = '0; err_d = 1'b0; tmo_d = 1'b0; over_d = 1'b0; tcnt_d = '0;
                    if (cmd_write) begin
                        wr_ready_d = 1'b1;
                        state_d = S_WFILL;
                    end else begin
                        ARVALID_d = 1'b1;
                        AR_OUT_d = {cmd_addr, cmd_len, cmd_id};
                        state_d = S_AR;
                    end
                end
            end
            S_WFILL: begin
                if (wr_valid && wr_ready) begin
                    buf_we = 1'b1;
                    if (cnt_q == len_q) begin
                        wr_ready_d = 1'b0;
                        cnt_d = '0;
                        tcnt_d = '0;
                        AWVALID_d = 1'b1;
                        AW_OUT_d = {addr_q, id_q};
                        state_d = S_AW;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_AW: begin
                bus_wait = 1'b1;
                if (AWREADY) begin
                    hs = 1'b1;
                    AWVALID_d = 1'b0;
                    WVALID_d = 1'b1;
                    WDATA_d = wbuf[4'd0];
                    WLAST_d = (len_q == '0);
                    cnt_d = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                bus_wait = 1'b1;
                if (WREADY) begin
                    hs = 1'b1;
                    if (WLAST) begin
                        WVALID_d = 1'b0;
                        WLAST_d = 1'b0;
                        BREADY_d = 1'b1;
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        WDATA_d = wbuf[cnt_q + 4'd1];
                        WLAST_d = ((cnt_q + 4'd1) == len_q);
                    end
                end
            end
            S_B: begin
                bus_wait = 1'b1;
                if (BVALID) begin
                    hs = 1'b1;
                    BREADY_d = 1'b0;
                    err_d = err_q | BRESP[4] | (BRESP[3:0] != id_q);
                    state_d = S_DONE;
                end
            end
            S_AR: begin
                bus_wait = 1'b1;
                if (ARREADY) begin
                    hs = 1'b1;
                    ARVALID_d = 1'b0;
                    RREADY_d = 1'b1;
                    cnt_d = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                bus_wait = 1'b1;
                if (RVALID) begin
                    hs = 1'b1;
                    // over_q marks beats past the 16th, which a saturated cnt can no longer tell apart.
                    if (!over_q && (cnt_q <= len_q)) begin
                        rd_valid_d = 1'b1;
                        rd_data_d = R_IN[8:1];
                        rd_err_d = R_IN[0];
                        rd_last_d = RLAST;
                        err_d = err_d | R_IN[0];
                    end else begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == 4'hF) over_d = 1'b1;
                    else cnt_d = cnt_q + 4'd1;
                    if (RLAST) begin
                        if (cnt_q < len_q) err_d = 1'b1;
                        RREADY_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                done_err_d = err_q;
                done_timeout_d = tmo_q;
                done_id_d = id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus_wait) begin
            if (hs) begin
                tcnt_d = '0;
            end else if (tmo_hit) begin
                ARVALID_d = 1'b0; RREADY_d = 1'b0; AWVALID_d = 1'b0;
                WVALID_d = 1'b0; WLAST_d = 1'b0; BREADY_d = 1'b0;
                err_d = 1'b1; tmo_d = 1'b1; tcnt_d = '0;
                state_d = S_DONE;
            end else begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: table-driven transactions against a small slave model, plus
// hand-written timeout and mid-burst reset sequences.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len, cmd_id;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid, rd_err, rd_last;
    logic [7:0]  rd_data;
    logic        done, done_err, done_timeout;
    logic [3:0]  done_id;
    logic        ARVALID, ARREADY, RREADY, RVALID, RLAST;
    logic [15:0] AR_OUT;
    logic [8:0]  R_IN;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [11:0] AW_OUT;
    logic [7:0]  WDATA;
    logic [4:0]  BRESP;

    always #5 clk = ~clk;

    bus_master #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_last(rd_last),
        .done(done), .done_err(done_err), .done_timeout(done_timeout), .done_id(done_id),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .AR_OUT(AR_OUT),
        .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .R_IN(R_IN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AW_OUT(AW_OUT),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [3:0]  len;
        logic [3:0]  id;
        logic [4:0]  bresp;
        int          nbeats;    // read beats the slave sends, RLAST on the last one
        logic [15:0] rerr;      // per-beat slave error bit
        logic [15:0] exp_word;  // AW_OUT (zero-extended) or AR_OUT
        int          exp_fwd;   // rd_valid pulses
        logic        exp_err;
        int          exp_iter;  // cycles after command edge until done is visible
    } vec_t;

    vec_t vecs [7];
    vec_t rv;
    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] mem [256];

    function automatic logic [60:0] all_outs();
        return {wr_ready, rd_valid, rd_data, rd_err, rd_last, done, done_err, done_timeout,
                done_id, ARVALID, AR_OUT, RREADY, AWVALID, AW_OUT, WVALID, WLAST, WDATA, BREADY};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_valid = 1'b0; wr_data = '0;
        ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        RVALID = 1'b0; RLAST = 1'b0; R_IN = '0;
        BVALID = 1'b0; BRESP = '0;
    endtask

    // Runs one transaction with a responsive slave; rst_beat >= 0 asserts rst when that write beat is presented.
    task automatic run_txn(input vec_t v, input int rst_beat);
        int wcount = 0, bytes = 0, rsent = 0, fwd = 0, iter = 0;
        bit seen_done = 0, bsent = 0, word_seen = 0, proto_bad = 0;
        logic [7:0] a;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_id = v.id;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!seen_done && iter < 100) begin
            if ((AWVALID && WVALID) || (ARVALID && RREADY)) proto_bad = 1;
            if (done) begin
                seen_done = 1;
                check("done_err", done_err, v.exp_err);
                check("done_timeout", done_timeout, 0);
                check("done_id", done_id, v.id);
                check("done_latency", iter, v.exp_iter);
            end
            if (wr_ready && bytes <= int'(v.len)) begin
                wr_valid = 1'b1; wr_data = 8'hA1 + 8'(bytes); bytes++;
            end else begin
                wr_valid = 1'b0;
            end
            if (AWVALID && !word_seen) begin
                word_seen = 1; check("aw_word", {4'h0, AW_OUT}, v.exp_word);
            end
            if (ARVALID && !word_seen) begin
                word_seen = 1; check("ar_word", AR_OUT, v.exp_word);
            end
            if (WVALID) begin
                if (wcount == rst_beat) begin
                    rst = 1'b1;
                    #1;
                    check("rst_outs_zero", all_outs(), 0);
                    check("rst_cmd_ready", cmd_ready, 0);
                    idle_inputs();
                    return;
                end
                check("wdata", WDATA, 8'hA1 + 8'(wcount));
                check("wlast", WLAST, wcount == int'(v.len));
                a = v.addr + 8'(wcount);
                mem[a] = WDATA;
                wcount++;
            end
            if (BREADY && !bsent) begin
                BVALID = 1'b1; BRESP = v.bresp; bsent = 1;
            end else begin
                BVALID = 1'b0;
            end
            if (rd_valid) begin
                a = v.addr + 8'(fwd);
                check("rd_data", rd_data, mem[a]);
                check("rd_err", rd_err, v.rerr[fwd]);
                check("rd_last", rd_last, fwd == v.nbeats - 1);
                fwd++;
            end
            if (RREADY && rsent < v.nbeats) begin
                a = v.addr + 8'(rsent);
                RVALID = 1'b1; R_IN = {mem[a], v.rerr[rsent]}; RLAST = (rsent == v.nbeats - 1);
                rsent++;
            end else begin
                RVALID = 1'b0; RLAST = 1'b0;
            end
            if (!seen_done) begin
                @(negedge clk);
                iter++;
            end
        end
        check("done_seen", seen_done, 1);
        check("fwd_count", fwd, v.exp_fwd);
        if (v.wr) check("w_count", wcount, int'(v.len) + 1);
        check("proto_overlap", proto_bad, 0);
        idle_inputs();
    endtask

    initial begin
        int arv, iter;
        bit seen_done, stray_done;
        vecs[0] = '{1'b1, 8'h10, 4'd3, 4'd5, 5'h05, 0, 16'h0, 16'h0105, 0, 1'b0, 11};
        vecs[1] = '{1'b0, 8'h10, 4'd3, 4'd5, 5'h00, 4, 16'h0, 16'h1035, 4, 1'b0, 6};
        vecs[2] = '{1'b1, 8'h20, 4'd0, 4'd3, 5'h13, 0, 16'h0, 16'h0203, 0, 1'b1, 5};
        vecs[3] = '{1'b1, 8'h30, 4'd1, 4'd3, 5'h04, 0, 16'h0, 16'h0303, 0, 1'b1, 7};
        vecs[4] = '{1'b0, 8'h10, 4'd1, 4'd7, 5'h00, 1, 16'h0, 16'h1017, 1, 1'b1, 3};
        vecs[5] = '{1'b0, 8'h10, 4'd0, 4'd2, 5'h00, 3, 16'h0, 16'h1002, 1, 1'b1, 5};
        vecs[6] = '{1'b0, 8'h12, 4'd1, 4'hC, 5'h00, 2, 16'h2, 16'h121C, 2, 1'b1, 4};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        idle_inputs();

        repeat (2) @(negedge clk);
        check("reset_outs_zero", all_outs(), 0);
        check("reset_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("release_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], -1);

        // Timeout: ARREADY held low, TIMEOUT=8.
        @(negedge clk);
        ARREADY = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50; cmd_len = 4'd0; cmd_id = 4'hA;
        @(negedge clk);
        cmd_valid = 1'b0;
        arv = 0; iter = 0; seen_done = 0;
        while (!seen_done && iter < 40) begin
            if (ARVALID) arv++;
            if (done) begin
                seen_done = 1;
                check("to_done_timeout", done_timeout, 1);
                check("to_done_err", done_err, 1);
                check("to_done_id", done_id, 4'hA);
                check("to_latency", iter, 9);
                check("to_cmd_ready", cmd_ready, 1);
            end else begin
                @(negedge clk);
                iter++;
            end
        end
        check("to_done_seen", seen_done, 1);
        check("to_arvalid_cycles", arv, 8);
        idle_inputs();

        // Reset during W on beat 2, then a normal read.
        rv = '{1'b1, 8'h40, 4'd3, 4'd6, 5'h06, 0, 16'h0, 16'h0406, 0, 1'b0, 11};
        run_txn(rv, 2);
        @(negedge clk);
        check("rst_hold_outs_zero", all_outs(), 0);
        rst = 1'b0;
        stray_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) stray_done = 1;
        end
        check("rst_no_done", stray_done, 0);
        check("rst_after_cmd_ready", cmd_ready, 1);
        rv = '{1'b0, 8'h10, 4'd3, 4'd4, 5'h00, 4, 16'h0, 16'h1034, 4, 1'b0, 6};
        run_txn(rv, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case a sequence stalls outside its own bounds.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/bus_master.md
# bus_master

Command-driven master that issues single read or write bursts onto the packed-field read/write bus of the 256x8 memory slave and returns data and status to a user-side client. It sits directly upstream of the slave: its address, data and ready outputs connect straight to the slave's inputs. Write data is collected into an internal 16-byte buffer before the address phase. Read data is forwarded beat by beat. Every wait state is guarded by a timeout.

## Interface
- TIMEOUT, 255: number of cycles without a handshake in any bus-wait state before the transaction aborts. Range 1..255; the timeout counter is 8 bits.
- clk in 1: clock, rising edge.
- rst in 1: reset, asynchronous, active-high.
- cmd_valid in 1: command request.
- cmd_ready out 1: equals (state==IDLE) && !rst.
- cmd_write in 1: 1 = write burst, 0 = read burst.
- cmd_addr in 8: start address.
- cmd_len in 4: number of beats minus 1.
- cmd_id in 4: transaction ID.
- wr_valid in 1: user write byte valid.
- wr_data in 8: user write byte.
- wr_ready out 1: buffer accepting bytes.
- rd_valid out 1: one-cycle read beat strobe. There is no backpressure on this interface.
- rd_data out 8: read byte.
- rd_err out 1: per-beat error bit from the slave.
- rd_last out 1: final forwarded beat.
- done out 1: one-cycle completion pulse.
- done_err out 1: transaction error.
- done_timeout out 1: transaction aborted by timeout.
- done_id out 4: ID of the completed transaction.
- ARVALID out 1: read address valid.
- ARREADY in 1: read address accepted.
- AR_OUT out 16: read address word, {addr[7:0], len[3:0], id[3:0]}.
- RREADY out 1: master ready for read beats.
- RVALID in 1: read beat valid.
- RLAST in 1: last read beat.
- R_IN in 9: read beat, {data[7:0], err}.
- AWVALID out 1: write address valid.
- AWREADY in 1: write address accepted.
- AW_OUT out 12: write address word, {addr[7:0], id[3:0]}.
- WVALID out 1: write beat valid.
- WREADY in 1: write beat accepted.
- WLAST out 1: last write beat.
- WDATA out 8: write byte.
- BVALID in 1: write response valid.
- BREADY out 1: master ready for write response.
- BRESP in 5: write response, {err, id[3:0]}.

## Operation
- States: IDLE, WFILL, AW, W, B, AR, R, DONE.
- IDLE:
  - The command is latched on cmd_valid && cmd_ready.
  - Goes to WFILL if cmd_write=1, otherwise to AR.
  - Latched items: addr, len, id.
  - Cleared items: beat counter, error flag, timeout flag.
- WFILL:
  - wr_ready=1.
  - Each wr_valid && wr_ready stores wr_data into buf[cnt], then cnt++.
  - After len+1 bytes have been stored: wr_ready=0, cnt is cleared, go to AW.
  - No timeout in WFILL.
- AW: AWVALID=1, AW_OUT={addr,id}. On AWREADY: AWVALID=0, go to W.
- W:
  - WVALID=1, WDATA=buf[cnt], WLAST=(cnt==len).
  - On WREADY, cnt++. If the accepted beat carried WLAST: WVALID=0, WLAST=0, go to B.
- B:
  - BREADY=1. On BVALID, BREADY=0.
  - err |= BRESP[4] | (BRESP[3:0]!=id).
  - Go to DONE.
- AR: ARVALID=1, AR_OUT={addr,len,id}. On ARREADY: ARVALID=0, go to R.
- R, behaviour on each beat (RVALID && RREADY):
  - If cnt<=len: rd_valid=1, rd_data=R_IN[8:1], rd_err=R_IN[0], rd_last=RLAST.
  - If cnt<=len: err |= R_IN[0].
  - If cnt>len: the beat is not forwarded and err is set.
  - cnt saturates at 15, with err set.
- R, exit conditions:
  - R exits to DONE on the beat carrying RLAST. RREADY drops the next cycle.
  - If RLAST arrives with cnt<len (fewer than len+1 beats), err is set.
- Timeout:
  - In AW, W, B, AR and R, an 8-bit counter increments each cycle with no handshake and clears on every handshake.
  - When the counter reaches TIMEOUT: all bus valid and ready outputs drop, err=1, timeout=1, go to DONE.
- DONE:
  - done=1 for one cycle, with done_err=err, done_timeout=timeout, done_id=id.
  - Go to IDLE.
- Reset mid-operation:
  - Immediate return to IDLE.
  - All outputs except cmd_ready reset to 0. cmd_ready is 0 while rst is asserted and 1 after rst is released.
  - Buffer contents are don't-care.
  - No done pulse is issued for the aborted transaction.

## Timing
- All outputs except cmd_ready are registered.
- Command accepted at edge N:
  - Write: wr_ready=1 from N+1.
  - Read: ARVALID=1 from N+1.
- Write fill: the last byte is accepted at edge M; AWVALID=1 from M+1.
- AW handshake:
  - AWREADY sampled at edge K: AWVALID=0 and WVALID=1 with beat 0 from K+1.
  - The one-cycle-low AWVALID gap before data is mandatory.
- Write beats:
  - One beat per cycle while WREADY=1.
  - Beats hold when WREADY=0, with WDATA and WLAST stable.
- AR handshake: ARREADY sampled at edge K gives ARVALID=0 and RREADY=1 from K+1. ARVALID and RREADY are never high together.
- Read forwarding latency: the beat sampled at edge J appears on rd_valid at J+1.
- Response to done:
  - BVALID sampled at edge J: done at J+2, via DONE state.
  - RLAST beat sampled at edge J: done at J+2.
- Minimum write transaction, single beat with immediate readies: 6 cycles from command to done.

## Test plan
- Write burst:
  - Stimulus: write addr=0x10, len=3, id=5, bytes 0xA1..0xA4; slave readies every cycle; BRESP=0x05.
  - Required: AW_OUT=0x105. WDATA sequence A1, A2, A3, A4, with WLAST on A4. done with done_err=0, done_id=5.
- Read-back:
  - Stimulus: read addr=0x10, len=3, id=5.
  - Required: AR_OUT=0x1035. Four rd_valid pulses A1..A4 with rd_last on the 4th. done_err=0.
- Response mismatch:
  - Stimulus: BRESP=0x13 for a write with id=3.
  - Required: done_err=1.
  - Stimulus: BRESP=0x04 for a write with id=3.
  - Required: done_err=1.
- Beat count errors:
  - Stimulus: read len=1, with RLAST on the 1st beat.
  - Required: one beat forwarded, done_err=1.
  - Stimulus: read len=0, with RLAST on the 3rd beat.
  - Required: only the 1st beat forwarded, done_err=1.
- Timeout:
  - Stimulus: ARREADY held 0, TIMEOUT=8.
  - Required: ARVALID drops 8 cycles after rising, done_timeout=1, done_err=1, then cmd_ready=1.
- Reset mid-burst:
  - Stimulus: rst asserted during W, on beat 2.
  - Required: all outputs 0 immediately, no done pulse; cmd_ready=1 after release. A new read completes normally.
